// File: rtl/dn_cmd_pkg.sv
// Shared constants and FSM state type for the FX2 downlink command parser.
package dn_cmd_pkg;

   localparam logic [15:0] SYNC0   = 16'h4F4C;
   localparam logic [15:0] SYNC1   = 16'h4450;
   localparam logic [15:0] TRAILER = 16'h00FF;
   localparam logic [7:0]  CMD_WR  = 8'h01;
   localparam logic [7:0]  CMD_RD  = 8'h02;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_SYNC1,
      ST_HDR,
      ST_DATA,
      ST_TRAIL
   } state_t;

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] cnt
);

   // count up on inc, hold once all ones
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != 16'hFFFF)) begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/dn_cmd_parser.sv
// Downlink command parser: decodes 8-word frames from the FX2 port into
// register writes and read requests, with framing recovery and idle timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_HUNT  | searching for the first sync word 0x4F4C
// ST_SYNC1 | first sync seen, expecting 0x4450 (0x4F4C re-arms here)
// ST_HDR   | expecting {cmd, addr}
// ST_DATA  | collecting four data words, MS word first
// ST_TRAIL | expecting trailer 0x00FF; frame is judged on this word
module dn_cmd_parser
   import dn_cmd_pkg::*;
#(
   parameter int NREG    = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dn_val,
   input  logic [15:0]        dn_dat,
   output logic               cfg_wr,
   output logic [7:0]         cfg_addr,
   output logic [63:0]        cfg_dat,
   output logic [NREG*64-1:0] reg_flat,
   output logic               rd_req,
   output logic [7:0]         rd_addr,
   output logic [15:0]        frm_ok_cnt,
   output logic [15:0]        frm_err_cnt
);

   // idle counter only has to reach TIMEOUT-1; the timeout fires on the
   // TIMEOUT-th consecutive idle cycle
   localparam int            IW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT - 1);
   localparam logic [8:0]    NREG9   = 9'(NREG);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    data_idx;
   logic [7:0]    cmd_q;
   logic [7:0]    addr_q;
   logic [63:0]   stage;
   logic [IW-1:0] idle_cnt;

   logic          frame_valid;
   logic          accept_ok;
   logic          accept_err;
   logic          timeout;
   logic          wr_commit;
   logic          rd_commit;

   assign frame_valid = (dn_dat == TRAILER)
                      && ((cmd_q == CMD_WR) || (cmd_q == CMD_RD))
                      && ({1'b0, addr_q} < NREG9);

   assign wr_commit = accept_ok && (cmd_q == CMD_WR);
   assign rd_commit = accept_ok && (cmd_q == CMD_RD);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and frame verdict; an accepted word always beats a timeout
   always_comb begin
      state_nxt  = state;
      accept_ok  = 1'b0;
      accept_err = 1'b0;
      timeout    = 1'b0;
      if (dn_val) begin
         case (state)
            ST_HUNT: begin
               if (dn_dat == SYNC0) state_nxt = ST_SYNC1;
            end
            ST_SYNC1: begin
               if (dn_dat == SYNC1)      state_nxt = ST_HDR;
               else if (dn_dat != SYNC0) state_nxt = ST_HUNT;
            end
            ST_HDR: begin
               state_nxt = ST_DATA;
            end
            ST_DATA: begin
               if (data_idx == 2'd3) state_nxt = ST_TRAIL;
            end
            ST_TRAIL: begin
               state_nxt = ST_HUNT;
               if (frame_valid) accept_ok  = 1'b1;
               else             accept_err = 1'b1;
            end
            default: begin
               state_nxt = ST_HUNT;
            end
         endcase
      end else if ((state != ST_HUNT) && (idle_cnt == TO_LAST)) begin
         state_nxt = ST_HUNT;
         timeout   = 1'b1;
      end
   end

   // idle counter; held at zero in HUNT where a timeout has no meaning
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
      end else if (dn_val || (state == ST_HUNT) || timeout) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // header capture, data word index and 64-bit staging shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q    <= '0;
         addr_q   <= '0;
         data_idx <= '0;
         stage    <= '0;
      end else if (timeout) begin
         stage    <= '0;
      end else if (dn_val) begin
         if (state == ST_HDR) begin
            cmd_q    <= dn_dat[15:8];
            addr_q   <= dn_dat[7:0];
            data_idx <= '0;
         end
         if (state == ST_DATA) begin
            stage    <= {stage[47:0], dn_dat};
            data_idx <= data_idx + 2'd1;
         end
      end
   end

   // commit pulses and the address/data of the last commit
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_wr   <= 1'b0;
         rd_req   <= 1'b0;
         cfg_addr <= '0;
         cfg_dat  <= '0;
         rd_addr  <= '0;
      end else begin
         cfg_wr <= wr_commit;
         rd_req <= rd_commit;
         if (wr_commit) begin
            cfg_addr <= addr_q;
            cfg_dat  <= stage;
         end
         if (rd_commit) begin
            rd_addr <= addr_q;
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_reg
      logic [63:0] reg_q;

      // one config register; loads only on a committed write to its index
      always_ff @(posedge clk) begin
         if (rst) begin
            reg_q <= '0;
         end else if (wr_commit && (addr_q == 8'(g))) begin
            reg_q <= stage;
         end
      end

      assign reg_flat[64*g +: 64] = reg_q;
   end

   sat_cnt16 u_ok_cnt (
      .clk (clk),
      .rst (rst),
      .inc (accept_ok),
      .cnt (frm_ok_cnt)
   );

   sat_cnt16 u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (accept_err | timeout),
      .cnt (frm_err_cnt)
   );

endmodule

// File: tb/tb_dn_cmd_parser.sv
// Bench for dn_cmd_parser: directed frames plus random traffic, checked
// every cycle against a queue-based frame model.
module tb_dn_cmd_parser;

   localparam int NR = 8;
   localparam int TO = 16;
   localparam logic [15:0] W_S0 = 16'h4F4C;
   localparam logic [15:0] W_S1 = 16'h4450;
   localparam logic [15:0] W_TR = 16'h00FF;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             dn_val = 1'b0;
   logic [15:0]      dn_dat = '0;
   logic             cfg_wr;
   logic [7:0]       cfg_addr;
   logic [63:0]      cfg_dat;
   logic [NR*64-1:0] reg_flat;
   logic             rd_req;
   logic [7:0]       rd_addr;
   logic [15:0]      frm_ok_cnt;
   logic [15:0]      frm_err_cnt;

   dn_cmd_parser #(.NREG(NR), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .dn_val      (dn_val),
      .dn_dat      (dn_dat),
      .cfg_wr      (cfg_wr),
      .cfg_addr    (cfg_addr),
      .cfg_dat     (cfg_dat),
      .reg_flat    (reg_flat),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .frm_ok_cnt  (frm_ok_cnt),
      .frm_err_cnt (frm_err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_frm[$];
   int          m_idle = 0;
   logic [63:0] m_reg[NR];
   logic        m_wr = 1'b0, m_rd = 1'b0;
   logic [7:0]  m_addr = '0, m_rd_addr = '0;
   logic [63:0] m_dat = '0;
   int          m_ok = 0, m_err = 0;
   bit          m_live = 1'b0;

   task automatic m_judge();
      logic [15:0] hdr;
      logic [7:0]  cmd, adr;
      logic [63:0] data;
      bit          good;
      hdr  = m_frm[2];
      cmd  = hdr[15:8];
      adr  = hdr[7:0];
      data = {m_frm[3], m_frm[4], m_frm[5], m_frm[6]};
      good = (m_frm[7] == W_TR) && (cmd == 8'h01 || cmd == 8'h02) && (int'(adr) < NR);
      if (good) begin
         if (m_ok < 65535) m_ok++;
         if (cmd == 8'h01) begin
            m_wr = 1'b1;
            m_addr = adr;
            m_dat = data;
            m_reg[int'(adr)] = data;
         end else begin
            m_rd = 1'b1;
            m_rd_addr = adr;
         end
      end else begin
         if (m_err < 65535) m_err++;
      end
   endtask

   task automatic m_word(input logic [15:0] w);
      if (m_frm.size() == 0) begin
         if (w == W_S0) m_frm.push_back(w);
      end else if (m_frm.size() == 1) begin
         if (w == W_S1) m_frm.push_back(w);
         else if (w != W_S0) m_frm.delete();
      end else begin
         m_frm.push_back(w);
         if (m_frm.size() == 8) begin
            m_judge();
            m_frm.delete();
         end
      end
   endtask

   // model steps on the same edge the DUT samples its inputs
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_frm.delete();
         m_idle = 0;
         for (int i = 0; i < NR; i++) m_reg[i] = '0;
         m_wr = 1'b0; m_rd = 1'b0;
         m_addr = '0; m_rd_addr = '0; m_dat = '0;
         m_ok = 0; m_err = 0;
         m_live = 1'b1;
      end else begin
         m_wr = 1'b0;
         m_rd = 1'b0;
         if (dn_val) begin
            m_idle = 0;
            m_word(dn_dat);
         end else if (m_frm.size() != 0) begin
            m_idle++;
            if (m_idle >= TO) begin
               m_frm.delete();
               m_idle = 0;
               if (m_err < 65535) m_err++;
            end
         end else begin
            m_idle = 0;
         end
      end
   end

   // compare DUT against model midway through every cycle
   always @(negedge clk) begin
      if (m_live) begin
         chk("cfg_wr", 64'(cfg_wr), 64'(m_wr));
         chk("rd_req", 64'(rd_req), 64'(m_rd));
         chk("cfg_addr", 64'(cfg_addr), 64'(m_addr));
         chk("cfg_dat", cfg_dat, m_dat);
         chk("rd_addr", 64'(rd_addr), 64'(m_rd_addr));
         chk("frm_ok_cnt", 64'(frm_ok_cnt), 64'(m_ok));
         chk("frm_err_cnt", 64'(frm_err_cnt), 64'(m_err));
         for (int i = 0; i < NR; i++)
            chk($sformatf("reg%0d", i), reg_flat[64*i +: 64], m_reg[i]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic [15:0] d);
      dn_val = v;
      dn_dat = d;
      @(posedge clk);
      #1;
      dn_val = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] adr,
                             input logic [63:0] data, input logic [15:0] trl,
                             input int gap);
      logic [15:0] w[8];
      w[0] = W_S0; w[1] = W_S1; w[2] = {cmd, adr};
      w[3] = data[63:48]; w[4] = data[47:32]; w[5] = data[31:16]; w[6] = data[15:0];
      w[7] = trl;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, w[i]);
         if (gap > 0 && i < 7)
            repeat ($urandom_range(0, gap)) drive(1'b0, 16'($urandom));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 16'($urandom));
   endtask

   function automatic logic [15:0] rnd_word();
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) return W_S0;
      if (r < 3) return W_S1;
      if (r < 4) return W_TR;
      return 16'($urandom);
   endfunction

   initial begin
      int c1, c2;
      logic [63:0] a, b, d;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_wr", 64'(cfg_wr), 64'd0);
      chk("rst_ok", 64'(frm_ok_cnt), 64'd0);
      chk("rst_regs", 64'(|reg_flat), 64'd0);
      rst = 1'b0;

      // all-zero write to reg 0
      send_frame(8'h01, 8'h00, 64'd0, W_TR, 0);
      chk("wr0_pulse", 64'(cfg_wr), 64'd1);
      chk("wr0_addr", 64'(cfg_addr), 64'd0);
      chk("wr0_dat", cfg_dat, 64'd0);
      chk("wr0_ok", 64'(frm_ok_cnt), 64'd1);

      // write reg 3, visible one cycle after the trailer
      send_frame(8'h01, 8'h03, 64'h0123_4567_89AB_CDEF, W_TR, 0);
      chk("wr3_reg", reg_flat[255:192], 64'h0123_4567_89AB_CDEF);
      chk("wr3_reg0", reg_flat[63:0], 64'd0);
      chk("wr3_ok", 64'(frm_ok_cnt), 64'd2);

      // bad trailer, then a good frame
      send_frame(8'h01, 8'h02, 64'hDEAD_BEEF_0000_1111, 16'h00FE, 0);
      chk("badtrl_wr", 64'(cfg_wr), 64'd0);
      chk("badtrl_err", 64'(frm_err_cnt), 64'd1);
      chk("badtrl_reg2", reg_flat[191:128], 64'd0);
      send_frame(8'h01, 8'h02, 64'hCAFE_F00D_1234_5678, W_TR, 0);
      chk("after_bad_wr", 64'(cfg_wr), 64'd1);
      chk("after_bad_reg2", reg_flat[191:128], 64'hCAFE_F00D_1234_5678);

      // timeout after W3: still pending at 15 idle, error at 16
      drive(1'b1, W_S0); drive(1'b1, W_S1); drive(1'b1, 16'h0104); drive(1'b1, 16'hAAAA);
      idle(TO - 1);
      chk("to_pending_err", 64'(frm_err_cnt), 64'd1);
      idle(1);
      chk("to_err", 64'(frm_err_cnt), 64'd2);
      chk("to_reg4", reg_flat[319:256], 64'd0);
      send_frame(8'h01, 8'h04, 64'h4444_0000_0000_0004, W_TR, 0);
      chk("to_recover_ok", 64'(frm_ok_cnt), 64'd4);

      // word arriving exactly on the timeout cycle is kept
      drive(1'b1, W_S0); drive(1'b1, W_S1); drive(1'b1, 16'h0106); drive(1'b1, 16'h6666);
      idle(TO - 1);
      drive(1'b1, 16'h5555); drive(1'b1, 16'h4444); drive(1'b1, 16'h3333); drive(1'b1, W_TR);
      chk("to_tie_wr", 64'(cfg_wr), 64'd1);
      chk("to_tie_reg6", reg_flat[447:384], 64'h6666_5555_4444_3333);
      chk("to_tie_err", 64'(frm_err_cnt), 64'd2);

      // resync through garbage, then a read of reg 5
      drive(1'b1, 16'h1234); drive(1'b1, W_S0); drive(1'b1, W_S0); drive(1'b1, W_S1);
      drive(1'b1, 16'h0205);
      drive(1'b1, 16'h1111); drive(1'b1, 16'h2222); drive(1'b1, 16'h3333); drive(1'b1, 16'h4444);
      drive(1'b1, W_TR);
      chk("rd_pulse", 64'(rd_req), 64'd1);
      chk("rd_addr5", 64'(rd_addr), 64'd5);
      chk("rd_no_wr", 64'(cfg_wr), 64'd0);
      chk("rd_reg5", reg_flat[383:320], 64'd0);
      send_frame(8'h01, 8'h08, 64'h8888, W_TR, 0);
      chk("addr8_err", 64'(frm_err_cnt), 64'd3);
      chk("addr8_wr", 64'(cfg_wr), 64'd0);

      // sync word inside data does not resync
      send_frame(8'h01, 8'h07, {W_S0, W_S0, 16'h1111, W_S0}, W_TR, 0);
      chk("sync_in_data", reg_flat[511:448], {W_S0, W_S0, 16'h1111, W_S0});

      // unknown command
      send_frame(8'h03, 8'h01, 64'h1, W_TR, 0);
      chk("badcmd_err", 64'(frm_err_cnt), 64'd4);

      // back-to-back writes, 8 cycles apart
      a = 64'hA5A5_0000_0000_0001;
      b = 64'h5A5A_0000_0000_0002;
      send_frame(8'h01, 8'h00, a, W_TR, 0);
      c1 = cyc;
      chk("b2b_wr1", 64'(cfg_wr), 64'd1);
      send_frame(8'h01, 8'h01, b, W_TR, 0);
      c2 = cyc;
      chk("b2b_wr2", 64'(cfg_wr), 64'd1);
      chk("b2b_gap", 64'(c2 - c1), 64'd8);
      chk("b2b_reg1", reg_flat[127:64], b);

      // reset lands on W5 of a third frame
      drive(1'b1, W_S0); drive(1'b1, W_S1); drive(1'b1, 16'h0102);
      drive(1'b1, 16'h7777); drive(1'b1, 16'h7777);
      rst = 1'b1;
      drive(1'b1, 16'h7777);
      rst = 1'b0;
      drive(1'b1, 16'h7777); drive(1'b1, W_TR);
      chk("rst_mid_wr", 64'(cfg_wr), 64'd0);
      chk("rst_mid_addr", 64'(cfg_addr), 64'd0);
      chk("rst_mid_dat", cfg_dat, 64'd0);
      chk("rst_mid_ok", 64'(frm_ok_cnt), 64'd0);
      chk("rst_mid_err", 64'(frm_err_cnt), 64'd0);
      chk("rst_mid_regs", 64'(|reg_flat), 64'd0);

      // random traffic
      for (int it = 0; it < 400; it++) begin
         int r, g;
         logic [7:0] cmd;
         r = $urandom_range(0, 99);
         if (r < 60) begin
            int rc;
            rc = $urandom_range(0, 99);
            cmd = (rc < 45) ? 8'h01 : (rc < 85) ? 8'h02 : 8'($urandom);
            d = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
            g = $urandom_range(0, 99);
            send_frame(cmd, 8'($urandom_range(0, 9)), d,
                       ($urandom_range(0, 9) == 0) ? rnd_word() : W_TR,
                       (g < 70) ? 0 : (g < 95) ? 3 : 20);
         end else if (r < 80) begin
            repeat ($urandom_range(1, 5)) drive(1'b1, rnd_word());
         end else if (r < 95) begin
            idle($urandom_range(0, 20));
         end else begin
            repeat ($urandom_range(0, 5)) drive(1'b1, rnd_word());
            rst = 1'b1;
            repeat ($urandom_range(1, 2)) drive(1'($urandom), rnd_word());
            rst = 1'b0;
         end
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dn_cmd_parser.md
DN_CMD_PARSER -- requirements
Module: dn_cmd_parser

Interface
REQ-001 Parameter NREG, default 8: number of 64-bit config registers, 1..256.
REQ-002 Parameter TIMEOUT, default 1024: max idle clk cycles between words inside a frame.
REQ-003 clk  in  1  single clock; the same clk that drives the FX2 slave-FIFO block.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 dn_val  in  1  one-cycle qualifier for dn_dat from the FX2 downlink port.
REQ-006 dn_dat  in  16  downlink word; the byte order is defined by the frame format in REQ-014.
REQ-007 cfg_wr  out  1  one-cycle pulse when a register write commits.
REQ-008 cfg_addr  out  8  register index of the last commit.
REQ-009 cfg_dat  out  64  data of the last commit.
REQ-010 reg_flat  out  NREG*64  all registers; reg i occupies bits [64i+63:64i].
REQ-011 rd_req  out  1  one-cycle pulse requesting that the uplink responder return a register.
REQ-012 rd_addr  out  8  register index for rd_req.
REQ-013 frm_ok_cnt, frm_err_cnt  out  16 each  saturating frame counters.

Function
REQ-014 A frame is 8 words, in order:
- W0 = 0x4F4C ("O","L")
- W1 = 0x4450 ("D","P")
- W2 = {cmd[7:0], addr[7:0]}
- W3..W6 = data[63:0], most significant word first
- W7 = trailer 0x00FF
REQ-015 The FSM has states HUNT, SYNC1, HDR, DATA (4 words, counted by a 2-bit counter), TRAIL. Each state advances only on dn_val.
REQ-016 HUNT: a word of 0x4F4C moves to SYNC1; any other word stays in HUNT.
REQ-017 SYNC1: 0x4450 moves to HDR; 0x4F4C stays in SYNC1; any other word returns to HUNT.
REQ-018 HDR latches cmd and addr. DATA shifts words into a 64-bit staging register. TRAIL checks the trailer.
REQ-019 Frame validity: trailer == 0x00FF, cmd is 0x01 (write) or 0x02 (read), and addr < NREG. Every other frame is an error.
REQ-020 Valid write: on the cycle after W7 is accepted, cfg_wr=1, cfg_addr=addr, cfg_dat=data, and reg[addr]=data. All three appear in the same cycle (latency 1).
REQ-021 Valid read: on the cycle after W7 is accepted, rd_req=1 and rd_addr=addr. Data is ignored and no register changes.
REQ-022 Registers change only on commit. A partial or invalid frame never modifies any register.
REQ-023 An error frame increments frm_err_cnt by 1, produces no pulse, and returns the FSM to HUNT. A valid frame increments frm_ok_cnt by 1.
REQ-024 Both counters saturate at 0xFFFF and do not wrap.
REQ-025 An idle counter clears on every dn_val. When it reaches TIMEOUT in any state other than HUNT, the FSM returns to HUNT, frm_err_cnt increments, and the staging register is discarded.
REQ-026 If a timeout and a dn_val occur in the same cycle, dn_val wins: the word is accepted and no timeout is recorded.
REQ-027 0x4F4C inside HDR, DATA or TRAIL is treated as data and does not resync. Only the trailer check or a timeout recovers framing.
REQ-028 Back-to-back frames are supported: W0 of the next frame may arrive on the cycle immediately after W7 and is decoded in HUNT, concurrently with the commit pulse.
REQ-029 cfg_wr and rd_req are never asserted together, and each is asserted for at most one cycle per frame.

Reset
REQ-030 With rst=1 on a clk edge:
- the FSM goes to HUNT
- every register, cfg_addr, cfg_dat, rd_addr, both counters, the idle counter and the staging register go to 0
- cfg_wr and rd_req go to 0
REQ-031 Reset asserted mid-frame aborts the frame with no commit and no counter increment.
REQ-032 The first word is decoded on the first clk edge with rst=0.

Structure
REQ-033 A shared package (dn_cmd_pkg) holds:
- constants SYNC0=0x4F4C, SYNC1=0x4450, TRAILER=0x00FF, CMD_WR=0x01, CMD_RD=0x02
- the FSM state enumeration
REQ-034 The frame FSM and the register bank are implemented in one module. The only natural sub-module is sat_cnt16, the saturating counter, instantiated twice.

Verification
REQ-035 Write path: frame 4F4C,4450,0100,0000,0000,0000,0000,00FF -> cfg_wr pulse with cfg_addr=0x00, cfg_dat=0, frm_ok_cnt=1.
REQ-036 Write to reg 3: frame with W2=0x0103 and data 0x0123_4567_89AB_CDEF -> reg_flat[255:192]=0x0123456789ABCDEF one cycle after W7; all other registers unchanged.
REQ-037 Bad trailer: W7=0x00FE -> no cfg_wr, frm_err_cnt=1, and the next valid frame commits normally.
REQ-038 Timeout: dn_val stops after W3, with TIMEOUT=16 -> HUNT after 16 idle cycles, frm_err_cnt=1, no register change.
REQ-039 Resync and read: leading garbage 0x1234,4F4C,4F4C,4450 followed by a read frame with W2=0x0205 -> rd_req pulse with rd_addr=5 and no cfg_wr; addr 0x08 with NREG=8 -> frm_err_cnt increments.
REQ-040 Back-to-back and reset: two write frames with zero gap -> two cfg_wr pulses 8 cycles apart; rst asserted at W5 of a third frame -> no commit and all outputs zero.
